// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory port arbiter.
//   arbState_t : arbiter FSM state encoding
//   owner_t    : port owner encoding (0 none, 1 CPU, 2 SCP), also the
//                value driven on the arbiter's owner output
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arbState_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_SCP  = 2'd2
  } owner_t;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 3;

  // The requester that did not get the previous grant.
  function automatic owner_t otherOwner(input owner_t o);
    return (o == OWN_CPU) ? OWN_SCP : OWN_CPU;
  endfunction

endpackage

// File: rtl/arb_rr_select.sv
// Two-way round-robin winner select (purely combinational).
//   cpuElig   in  1 : CPU request is eligible this cycle
//   scpElig   in  1 : SCP request is eligible this cycle
//   lastGrant in  2 : requester granted most recently
//   winner    out 2 : OWN_NONE when nobody is eligible
module arb_rr_select
  import memory_arbiter_pkg::*;
(
  input  logic   cpuElig,
  input  logic   scpElig,
  input  owner_t lastGrant,
  output owner_t winner
);

  always_comb begin
    winner = OWN_NONE;
    if (cpuElig && scpElig) begin
      winner = otherOwner(lastGrant);
    end else if (cpuElig) begin
      winner = OWN_CPU;
    end else if (scpElig) begin
      winner = OWN_SCP;
    end
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbitrates a single memory port between the CPU and the serial command
// processor (SCP). One transaction at a time; round-robin on contention.
//   clk, rst                       : clock, async active-high reset
//   cpu_req/we/addr/wdata          : CPU request (held until cpu_ack)
//   cpu_ack/cpu_rdata              : CPU completion pulse / last read data
//   scp_*                          : same set for the SCP
//   cpu_halt                       : CPU held in reset, its requests ignored
//   mem_we/re/addr/wdata/rdata     : memory port, read data valid
//                                    READ_LATENCY cycles after mem_re issue
//   owner                          : current grant (0 none, 1 CPU, 2 SCP)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | port free, owner=0; latch winner and its request fields
// ST_ISSUE | drive latched request; write strobe or first read cycle
// ST_WAIT  | hold mem_re, count down read latency, capture read data
// ST_DONE  | one-cycle ack pulse to the owner
module memory_port_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              scp_req,
  input  logic              scp_we,
  input  logic [ADDR_W-1:0] scp_addr,
  input  logic [DATA_W-1:0] scp_wdata,
  output logic              scp_ack,
  output logic [DATA_W-1:0] scp_rdata,
  input  logic              cpu_halt,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  // ISSUE already accounts for one latency cycle, so WAIT counts down
  // from READ_LATENCY-1 and captures on terminal count zero.
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(READ_LATENCY - 1);

  arbState_t         state, stateNext;
  owner_t            ownerQ, lastGrant, winner;
  logic              latWe;
  logic [ADDR_W-1:0] latAddr;
  logic [DATA_W-1:0] latWdata;
  logic [CNT_W-1:0]  waitCnt;
  logic [DATA_W-1:0] cpuRdataQ, scpRdataQ;
  logic              cpuElig, scpElig;

  assign cpuElig = cpu_req & ~cpu_halt;
  assign scpElig = scp_req;

  arb_rr_select uSelect (
    .cpuElig   (cpuElig),
    .scpElig   (scpElig),
    .lastGrant (lastGrant),
    .winner    (winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_ack   = 1'b0;
    scp_ack   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (winner != OWN_NONE) stateNext = ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_addr  = latAddr;
        mem_wdata = latWdata;
        if (latWe) begin
          mem_we    = 1'b1;
          stateNext = ST_DONE;
        end else begin
          mem_re    = 1'b1;
          stateNext = ST_WAIT;
        end
      end
      ST_WAIT: begin
        mem_re    = 1'b1;
        mem_addr  = latAddr;
        mem_wdata = latWdata;
        if (waitCnt == '0) stateNext = ST_DONE;
      end
      ST_DONE: begin
        cpu_ack   = (ownerQ == OWN_CPU);
        scp_ack   = (ownerQ == OWN_SCP);
        stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // Request latch, grant history, latency timer and read-data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ownerQ    <= OWN_NONE;
      lastGrant <= OWN_CPU;
      latWe     <= 1'b0;
      latAddr   <= '0;
      latWdata  <= '0;
      waitCnt   <= '0;
      cpuRdataQ <= '0;
      scpRdataQ <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (winner != OWN_NONE) begin
            ownerQ    <= winner;
            lastGrant <= winner;
            latWe     <= (winner == OWN_CPU) ? cpu_we    : scp_we;
            latAddr   <= (winner == OWN_CPU) ? cpu_addr  : scp_addr;
            latWdata  <= (winner == OWN_CPU) ? cpu_wdata : scp_wdata;
          end
        end
        ST_ISSUE: begin
          waitCnt <= WAIT_LOAD;
        end
        ST_WAIT: begin
          if (waitCnt == '0) begin
            if (ownerQ == OWN_CPU) cpuRdataQ <= mem_rdata;
            if (ownerQ == OWN_SCP) scpRdataQ <= mem_rdata;
          end else begin
            waitCnt <= waitCnt - 3'd1;
          end
        end
        ST_DONE: begin
          ownerQ <= OWN_NONE;
        end
        default: ;
      endcase
    end
  end

  assign cpu_rdata = cpuRdataQ;
  assign scp_rdata = scpRdataQ;
  assign owner     = ownerQ;

endmodule
